// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, blanking, sync, DE and line/frame strobes for the video path.
// Latency: hc/vc are combinational from the counters; every flag and strobe lags its count by one pixel enable.
// Backpressure: none; free-running, advances only when clk_pix is high, geometry reloads only at frame wrap.
module video_timing_gen #(
  parameter int HW    = 9,
  parameter int VW    = 9,
  parameter int H_OFS = 32,
  parameter int V_OFS = 0,
  parameter int FCW   = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_clk_pix,
  input  logic [HW-1:0]  i_h_total,
  input  logic [HW-1:0]  i_h_bl_start,
  input  logic [HW-1:0]  i_h_bl_end,
  input  logic [HW-1:0]  i_h_s_start,
  input  logic [HW-1:0]  i_h_s_end,
  input  logic [VW-1:0]  i_v_total,
  input  logic [VW-1:0]  i_v_bl_start,
  input  logic [VW-1:0]  i_v_bl_end,
  input  logic [VW-1:0]  i_v_s_start,
  input  logic [VW-1:0]  i_v_s_end,
  input  logic [HW-1:0]  i_hs_offset,
  input  logic [VW-1:0]  i_vs_offset,
  output logic [HW-1:0]  o_hc,
  output logic [VW-1:0]  o_vc,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_hbl,
  output logic           o_vbl,
  output logic           o_de,
  output logic           o_line_start,
  output logic           o_frame_start,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam logic [HW-1:0] LP_H_OFS = HW'(H_OFS);
  localparam logic [VW-1:0] LP_V_OFS = VW'(V_OFS);

  // Shadow copies of the geometry; the raster only ever compares against these.
  logic [HW-1:0] r_h_total, r_h_bl_start, r_h_bl_end, r_h_s_start, r_h_s_end, r_hs_offset;
  logic [VW-1:0] r_v_total, r_v_bl_start, r_v_bl_end, r_v_s_start, r_v_s_end, r_vs_offset;

  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  logic           r_hsync, r_vsync, r_hbl, r_vbl, r_de;
  logic           r_line_start, r_frame_start;
  logic [FCW-1:0] r_frame_cnt;

  logic w_h_wrap, w_v_wrap, w_frame_wrap;
  logic w_hbl_next, w_vbl_next, w_hsync_next, w_vsync_next;
  logic w_hs_set, w_hs_clr, w_vs_set, w_vs_clr;

  // Sync edges are start/end plus a signed offset, evaluated one bit wider so a
  // negative result shows up in the top bit and can be suppressed.
  logic [HW:0] w_hs_set_t, w_hs_clr_t;
  logic [VW:0] w_vs_set_t, w_vs_clr_t;

  assign w_hs_set_t = {1'b0, r_h_s_start} + {r_hs_offset[HW-1], r_hs_offset};
  assign w_hs_clr_t = {1'b0, r_h_s_end}   + {r_hs_offset[HW-1], r_hs_offset};
  assign w_vs_set_t = {1'b0, r_v_s_start} + {r_vs_offset[VW-1], r_vs_offset};
  assign w_vs_clr_t = {1'b0, r_v_s_end}   + {r_vs_offset[VW-1], r_vs_offset};

  // An edge target that is negative or past the last count never matches.
  assign w_hs_set = !w_hs_set_t[HW] && (w_hs_set_t[HW-1:0] <= r_h_total) && (w_hs_set_t[HW-1:0] == r_h);
  assign w_hs_clr = !w_hs_clr_t[HW] && (w_hs_clr_t[HW-1:0] <= r_h_total) && (w_hs_clr_t[HW-1:0] == r_h);
  assign w_vs_set = !w_vs_set_t[VW] && (w_vs_set_t[VW-1:0] <= r_v_total) && (w_vs_set_t[VW-1:0] == r_v);
  assign w_vs_clr = !w_vs_clr_t[VW] && (w_vs_clr_t[VW-1:0] <= r_v_total) && (w_vs_clr_t[VW-1:0] == r_v);

  // Wrap detection and next flag values; set edges win over clear edges.
  always_comb begin
    w_h_wrap     = (r_h >= r_h_total);
    w_v_wrap     = (r_v >= r_v_total);
    w_frame_wrap = w_h_wrap && w_v_wrap;

    w_hbl_next = r_hbl;
    if (r_h == r_h_bl_start)    w_hbl_next = 1'b1;
    else if (r_h == r_h_bl_end) w_hbl_next = 1'b0;

    w_vbl_next = r_vbl;
    if (r_v == r_v_bl_start)    w_vbl_next = 1'b1;
    else if (r_v == r_v_bl_end) w_vbl_next = 1'b0;

    w_hsync_next = r_hsync;
    if (w_hs_set)      w_hsync_next = 1'b1;
    else if (w_hs_clr) w_hsync_next = 1'b0;

    w_vsync_next = r_vsync;
    if (w_vs_set)      w_vsync_next = 1'b1;
    else if (w_vs_clr) w_vsync_next = 1'b0;
  end

  // Capture the config ports at reset and on the pixel that wraps the frame.
  always_ff @(posedge i_clk) begin
    if (i_reset || (i_clk_pix && w_frame_wrap)) begin
      r_h_total    <= i_h_total;
      r_h_bl_start <= i_h_bl_start;
      r_h_bl_end   <= i_h_bl_end;
      r_h_s_start  <= i_h_s_start;
      r_h_s_end    <= i_h_s_end;
      r_hs_offset  <= i_hs_offset;
      r_v_total    <= i_v_total;
      r_v_bl_start <= i_v_bl_start;
      r_v_bl_end   <= i_v_bl_end;
      r_v_s_start  <= i_v_s_start;
      r_v_s_end    <= i_v_s_end;
      r_vs_offset  <= i_vs_offset;
    end
  end

  // Raster counters; an over-range h after a shrinking reload wraps like h_total.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clk_pix) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Blanking, sync and DE flags, one pixel behind the count they decode.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hbl   <= 1'b0;
      r_vbl   <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_de    <= 1'b0;
    end else if (i_clk_pix) begin
      r_hbl   <= w_hbl_next;
      r_vbl   <= w_vbl_next;
      r_hsync <= w_hsync_next;
      r_vsync <= w_vsync_next;
      r_de    <= ~w_hbl_next & ~w_vbl_next;
    end
  end

  // Single-clock line/frame strobes and the completed-frame counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_line_start  <= i_clk_pix && w_h_wrap;
      r_frame_start <= i_clk_pix && w_frame_wrap;
      if (i_clk_pix && w_frame_wrap) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign o_hc          = r_h - LP_H_OFS;
  assign o_vc          = r_v - LP_V_OFS;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_hbl         = r_hbl;
  assign o_vbl         = r_vbl;
  assign o_de          = r_de;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: table of geometries plus hand sequences for reload, slow pixel enable and reset.
// Expected outputs are pushed to a queue as each clock is driven and popped after the edge.
// All loops are bounded by fixed cycle counts.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset, clk_pix;
  logic [8:0] h_total, h_bl_start, h_bl_end, h_s_start, h_s_end, hs_offset;
  logic [8:0] v_total, v_bl_start, v_bl_end, v_s_start, v_s_end, vs_offset;
  logic [8:0] hc, vc;
  logic       hsync, vsync, hbl, vbl, de, line_start, frame_start;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .i_clk(clk), .i_reset(reset), .i_clk_pix(clk_pix),
    .i_h_total(h_total), .i_h_bl_start(h_bl_start), .i_h_bl_end(h_bl_end),
    .i_h_s_start(h_s_start), .i_h_s_end(h_s_end),
    .i_v_total(v_total), .i_v_bl_start(v_bl_start), .i_v_bl_end(v_bl_end),
    .i_v_s_start(v_s_start), .i_v_s_end(v_s_end),
    .i_hs_offset(hs_offset), .i_vs_offset(vs_offset),
    .o_hc(hc), .o_vc(vc), .o_hsync(hsync), .o_vsync(vsync), .o_hbl(hbl), .o_vbl(vbl),
    .o_de(de), .o_line_start(line_start), .o_frame_start(frame_start), .o_frame_cnt(frame_cnt)
  );

  // Config inputs plus hand-derived effective sync edges (-1: that edge never happens)
  // and the frame count expected after running the given number of frames.
  typedef struct {
    int ht, vt, hbs, hbe, hss, hse, hso, vbs, vbe, vss, vse, vso;
    int hs_set, hs_clr, vs_set, vs_clr;
    int frames;
  } vec_t;

  typedef struct packed {
    logic [8:0] hc;
    logic [8:0] vc;
    logic hs, vs, hb, vb, de, ls, fs;
    logic [7:0] fc;
  } obs_t;

  obs_t sb_q[$];
  obs_t last;
  vec_t tbl[5];
  vec_t cur, sh;
  int   m_h, m_v, m_fc;
  bit   s_hb, s_vb, s_hs, s_vs;
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  function automatic logic [8:0] hc_of(int h);
    return 9'((h - 32) & 511);
  endfunction

  // Cyclic window [s,e); equal ends mean the set edge always wins.
  function automatic bit inwin(int x, int s, int e);
    if (s == e) return 1'b1;
    if (s < e) return (x >= s) && (x < e);
    return (x >= s) || (x < e);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t c);
    h_total = 9'(c.ht);  h_bl_start = 9'(c.hbs); h_bl_end = 9'(c.hbe);
    h_s_start = 9'(c.hss); h_s_end = 9'(c.hse); hs_offset = 9'(c.hso);
    v_total = 9'(c.vt);  v_bl_start = 9'(c.vbs); v_bl_end = 9'(c.vbe);
    v_s_start = 9'(c.vss); v_s_end = 9'(c.vse); vs_offset = 9'(c.vso);
    cur = c;
  endtask

  // Drive one clock, push the expected post-edge outputs, then pop and compare.
  task automatic step(input bit rst, input bit pix, input string tag);
    obs_t e, got;
    int hp, vp;
    reset   = rst;
    clk_pix = pix;
    e = '0;
    if (rst) begin
      sh = cur; m_h = 0; m_v = 0; m_fc = 0;
      s_hb = 0; s_vb = 0; s_hs = 0; s_vs = 0;
      e.hc = hc_of(0);
    end else if (pix) begin
      hp = m_h; vp = m_v;
      if (hp == sh.hbs) s_hb = 1;
      if (vp == sh.vbs) s_vb = 1;
      if (sh.hs_set >= 0 && hp == sh.hs_set) s_hs = 1;
      if (sh.vs_set >= 0 && vp == sh.vs_set) s_vs = 1;
      e.hb = s_hb && inwin(hp, sh.hbs, sh.hbe);
      e.vb = s_vb && inwin(vp, sh.vbs, sh.vbe);
      e.hs = s_hs && (sh.hs_clr < 0 || inwin(hp, sh.hs_set, sh.hs_clr));
      e.vs = s_vs && (sh.vs_clr < 0 || inwin(vp, sh.vs_set, sh.vs_clr));
      e.de = !e.hb && !e.vb;
      e.ls = (hp == sh.ht);
      e.fs = e.ls && (vp == sh.vt);
      if (e.fs) m_fc = (m_fc + 1) % 256;
      if (e.ls) begin
        m_h = 0;
        m_v = (vp == sh.vt) ? 0 : vp + 1;
      end else begin
        m_h = hp + 1;
      end
      if (e.fs) sh = cur;
      e.hc = hc_of(m_h);
      e.vc = 9'(m_v);
      e.fc = 8'(m_fc);
    end else begin
      e = last;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    last = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    stepn++;
    e = sb_q.pop_front();
    got = {hc, vc, hsync, vsync, hbl, vbl, de, line_start, frame_start, frame_cnt};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sb_%s step %0d got %h expected %h", tag, stepn, got, e);
    end
  endtask

  initial begin
    vec_t base, chg;
    int   ls_cnt, fs_cnt, fs_prev, n;
    //          ht   vt hbs  hbe hss  hse  hso vbs vbe vss vse vso  hsS  hsC vsS vsC fr
    tbl[0] = '{385, 3, 351, 31, 363, 379,  -4,  2,  0,  1,  2,  0, 359, 375,  1,  2, 2};
    tbl[1] = '{385, 3, 351, 31, 363, 379,  20,  2,  0,  1,  2, -1, 383,  -1,  0,  1, 2};
    tbl[2] = '{385, 3, 351, 31, 363, 379,  30,  2,  0,  1,  2,  3,  -1,  -1, -1, -1, 2};
    tbl[3] = '{ 15, 5,  12, 12,   2,   5,  -3,  4,  1,  0,  3,  2,  -1,   2,  2,  5, 3};
    tbl[4] = '{ 15, 5,   0,  8,  10,  14,   5,  5,  5,  3,  3,  0,  15,  -1,  3,  3, 3};
    base   = '{ 15, 5,  12,  3,   4,   8,   0,  4,  1,  2,  3,  0,   4,   8,  2,  3, 0};
    chg    = base;
    chg.hbs = 10;
    chg.vbs = 3;

    reset = 1'b1; clk_pix = 1'b0;
    drive_cfg(tbl[0]);

    // Geometry table: reset, run whole frames, confirm the completed-frame count.
    for (int r = 0; r < 5; r++) begin
      drive_cfg(tbl[r]);
      step(1, 1, "reset");
      chk("reset_hc", int'(hc), 480);
      chk("reset_flags", int'({hsync, vsync, hbl, vbl, de, line_start, frame_start}), 0);
      for (int i = 0; i < tbl[r].frames * (tbl[r].ht + 1) * (tbl[r].vt + 1); i++)
        step(0, 1, "table");
      chk("table_frame_cnt", int'(frame_cnt), tbl[r].frames);
    end

    // Mid-frame config change only takes effect after the next frame wrap.
    drive_cfg(base);
    step(1, 1, "reload_rst");
    n = 0;
    while (!(m_v == 2 && m_h == 7) && n < 200) begin
      step(0, 1, "reload_pre");
      n++;
    end
    drive_cfg(chg);
    for (int i = 0; i < 3 * 96; i++) step(0, 1, "reload");
    chk("reload_frame_cnt", int'(frame_cnt), 3);

    // Pixel enable 1-in-4: rate, strobe width and hold are all scoreboarded.
    drive_cfg(tbl[3]);
    step(1, 1, "slow_rst");
    ls_cnt = 0; fs_cnt = 0; fs_prev = -1;
    for (int i = 0; i < 800; i++) begin
      step(0, (i % 4) == 0, "slow");
      if (line_start) ls_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_prev >= 0) chk("slow_frame_period", i - fs_prev, 384);
        fs_prev = i;
      end
    end
    chk("slow_line_starts", ls_cnt, 12);
    chk("slow_frame_starts", fs_cnt, 2);

    // Reset asserted for one clock in the middle of the second frame.
    drive_cfg(tbl[0]);
    step(1, 1, "midrst_rst");
    n = 0;
    while (!(m_fc == 1 && m_v == 1 && m_h == 200) && n < 5000) begin
      step(0, 1, "midrst_pre");
      n++;
    end
    chk("midrst_pre_frame_cnt", int'(frame_cnt), 1);
    step(1, 1, "midrst");
    chk("midrst_hc", int'(hc), 480);
    chk("midrst_vc", int'(vc), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    for (int i = 0; i < 400; i++) step(0, 1, "midrst_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
